// File: rtl/bram_dual_port_pipelined.sv
// True dual-port block RAM: per-byte write masks, 1- or 2-cycle read latency,
// selectable same-port read-during-write result, collision and out-of-range flags.

// Per-port output pipeline: valid shifts every cycle, data stages load only
// behind a valid so the output word holds between pulses.
module bram_dp_rd_pipe #(
  parameter int W   = 32,
  parameter int LAT = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         fire_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         valid_o
);
  logic [LAT:1]        vld_pipe_q, vld_pipe_d;
  logic [LAT:1][W-1:0] dat_pipe_q, dat_pipe_d;

  // Next-state of the valid shift register and the gated data stages
  always_comb begin
    vld_pipe_d    = vld_pipe_q << 1;
    vld_pipe_d[1] = fire_i;
    dat_pipe_d    = dat_pipe_q;
    if (fire_i) dat_pipe_d[1] = data_i;
    for (int s = 2; s <= LAT; s++)
      if (vld_pipe_q[s-1]) dat_pipe_d[s] = dat_pipe_q[s-1];
  end

  // Pipeline registers; reset drops everything in flight
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_pipe_q <= '0;
      dat_pipe_q <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      dat_pipe_q <= dat_pipe_d;
    end
  end

  assign data_o  = dat_pipe_q[LAT];
  assign valid_o = vld_pipe_q[LAT];
endmodule

module bram_dual_port_pipelined #(
  parameter int    DATA_WIDTH   = 32,
  parameter int    BRAM_DEPTH   = 128,
  parameter int    READ_LATENCY = 1,
  parameter string RDW_MODE     = "NO_CHANGE",
  localparam int   ADDR_WIDTH   = $clog2(BRAM_DEPTH)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    a_cmd_en_i,
  input  logic                    a_wr_en_i,
  input  logic [ADDR_WIDTH-1:0]   a_addr_i,
  input  logic [DATA_WIDTH-1:0]   a_data_i,
  input  logic [DATA_WIDTH/8-1:0] a_mask_i,
  output logic [DATA_WIDTH-1:0]   a_data_o,
  output logic                    a_valid_o,
  input  logic                    b_cmd_en_i,
  input  logic                    b_wr_en_i,
  input  logic [ADDR_WIDTH-1:0]   b_addr_i,
  input  logic [DATA_WIDTH-1:0]   b_data_i,
  input  logic [DATA_WIDTH/8-1:0] b_mask_i,
  output logic [DATA_WIDTH-1:0]   b_data_o,
  output logic                    b_valid_o,
  output logic                    collision_o,
  output logic                    oob_o
);
  localparam int NB       = DATA_WIDTH / 8;
  localparam bit RDW_NONE = (RDW_MODE == "NO_CHANGE");
  localparam bit RDW_WF   = (RDW_MODE == "WRITE_FIRST");

  // Port index 0 = A, 1 = B
  logic [1:0]                 cmd_en, wr_en, inr, we, fire;
  logic [1:0][ADDR_WIDTH-1:0] addr;
  logic [1:0][DATA_WIDTH-1:0] wdata, rd_word, rd_data;
  logic [1:0][NB-1:0]         mask;
  logic [1:0]                 rd_vld;
  logic [DATA_WIDTH-1:0]      old_w, new_w;
  logic                       collision_q, oob_q;

  logic [DATA_WIDTH-1:0] mem_q [BRAM_DEPTH] = '{default: '0};

  assign cmd_en = {b_cmd_en_i, a_cmd_en_i};
  assign wr_en  = {b_wr_en_i,  a_wr_en_i};
  assign addr   = {b_addr_i,   a_addr_i};
  assign wdata  = {b_data_i,   a_data_i};
  assign mask   = {b_mask_i,   a_mask_i};

  function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] base,
                                                  input logic [DATA_WIDTH-1:0] wd,
                                                  input logic [NB-1:0]         m);
    logic [DATA_WIDTH-1:0] r;
    r = base;
    for (int k = 0; k < NB; k++)
      if (m[k]) r[8*k +: 8] = wd[8*k +: 8];
    return r;
  endfunction

  // Decode range/write qualifiers and the word each port returns. The post-write
  // word folds in both ports, B first then A, so A owns its masked bytes.
  always_comb begin
    inr     = '0;
    we      = '0;
    fire    = '0;
    rd_word = '0;
    old_w   = '0;
    new_w   = '0;
    for (int p = 0; p < 2; p++) begin
      inr[p]  = {1'b0, addr[p]} < (ADDR_WIDTH+1)'(BRAM_DEPTH);
      we[p]   = cmd_en[p] & wr_en[p] & inr[p];
      fire[p] = cmd_en[p] & (~wr_en[p] | ~RDW_NONE);
    end
    for (int p = 0; p < 2; p++) begin
      old_w = inr[p] ? mem_q[addr[p]] : '0;
      new_w = old_w;
      if (we[1] && addr[1] == addr[p]) new_w = merge(new_w, wdata[1], mask[1]);
      if (we[0] && addr[0] == addr[p]) new_w = merge(new_w, wdata[0], mask[0]);
      rd_word[p] = (wr_en[p] && RDW_WF) ? new_w : old_w;
    end
  end

  // Array write; A's assignment comes last so it wins overlapping bytes
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NB; k++) begin
      if (we[1] && mask[1][k]) mem_q[addr[1]][8*k +: 8] <= wdata[1][8*k +: 8];
      if (we[0] && mask[0][k]) mem_q[addr[0]][8*k +: 8] <= wdata[0][8*k +: 8];
    end
  end

  // Status flags, always one cycle after the command regardless of read latency
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      collision_q <= 1'b0;
      oob_q       <= 1'b0;
    end else begin
      collision_q <= (&cmd_en) & (addr[0] == addr[1]) & (|wr_en) & inr[0];
      oob_q       <= |(cmd_en & ~inr);
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    bram_dp_rd_pipe #(.W(DATA_WIDTH), .LAT(READ_LATENCY)) u_rd_pipe (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .fire_i  (fire[p]),
      .data_i  (rd_word[p]),
      .data_o  (rd_data[p]),
      .valid_o (rd_vld[p])
    );
  end

  assign a_data_o    = rd_data[0];
  assign a_valid_o   = rd_vld[0];
  assign b_data_o    = rd_data[1];
  assign b_valid_o   = rd_vld[1];
  assign collision_o = collision_q;
  assign oob_o       = oob_q;
endmodule

// File: tb/tb_bram_dual_port_pipelined.sv
// Bench: four configurations driven in lockstep, checked against a word-level
// memory model with a response schedule per port.
module tb_bram_dual_port_pipelined;
  localparam int NI = 4;
  localparam int DEP  [NI] = '{100, 100, 100, 128};
  localparam int LAT  [NI] = '{1, 2, 1, 2};
  localparam int MODE [NI] = '{0, 1, 2, 0};   // 0 no-change, 1 read-first, 2 write-first

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        a_en, a_wr, b_en, b_wr;
  logic [6:0]  a_addr, b_addr;
  logic [31:0] a_din, b_din;
  logic [3:0]  a_mask, b_mask;
  logic [31:0] ao_d [NI], bo_d [NI];
  logic        ao_v [NI], bo_v [NI], col [NI], oob [NI];

  always #5 clk = ~clk;

  bram_dual_port_pipelined #(.DATA_WIDTH(32), .BRAM_DEPTH(100), .READ_LATENCY(1), .RDW_MODE("NO_CHANGE")) u0 (
    .clk_i(clk), .rst_ni(rst_n),
    .a_cmd_en_i(a_en), .a_wr_en_i(a_wr), .a_addr_i(a_addr), .a_data_i(a_din), .a_mask_i(a_mask),
    .a_data_o(ao_d[0]), .a_valid_o(ao_v[0]),
    .b_cmd_en_i(b_en), .b_wr_en_i(b_wr), .b_addr_i(b_addr), .b_data_i(b_din), .b_mask_i(b_mask),
    .b_data_o(bo_d[0]), .b_valid_o(bo_v[0]), .collision_o(col[0]), .oob_o(oob[0]));
  bram_dual_port_pipelined #(.DATA_WIDTH(32), .BRAM_DEPTH(100), .READ_LATENCY(2), .RDW_MODE("READ_FIRST")) u1 (
    .clk_i(clk), .rst_ni(rst_n),
    .a_cmd_en_i(a_en), .a_wr_en_i(a_wr), .a_addr_i(a_addr), .a_data_i(a_din), .a_mask_i(a_mask),
    .a_data_o(ao_d[1]), .a_valid_o(ao_v[1]),
    .b_cmd_en_i(b_en), .b_wr_en_i(b_wr), .b_addr_i(b_addr), .b_data_i(b_din), .b_mask_i(b_mask),
    .b_data_o(bo_d[1]), .b_valid_o(bo_v[1]), .collision_o(col[1]), .oob_o(oob[1]));
  bram_dual_port_pipelined #(.DATA_WIDTH(32), .BRAM_DEPTH(100), .READ_LATENCY(1), .RDW_MODE("WRITE_FIRST")) u2 (
    .clk_i(clk), .rst_ni(rst_n),
    .a_cmd_en_i(a_en), .a_wr_en_i(a_wr), .a_addr_i(a_addr), .a_data_i(a_din), .a_mask_i(a_mask),
    .a_data_o(ao_d[2]), .a_valid_o(ao_v[2]),
    .b_cmd_en_i(b_en), .b_wr_en_i(b_wr), .b_addr_i(b_addr), .b_data_i(b_din), .b_mask_i(b_mask),
    .b_data_o(bo_d[2]), .b_valid_o(bo_v[2]), .collision_o(col[2]), .oob_o(oob[2]));
  bram_dual_port_pipelined #(.DATA_WIDTH(32), .BRAM_DEPTH(128), .READ_LATENCY(2), .RDW_MODE("NO_CHANGE")) u3 (
    .clk_i(clk), .rst_ni(rst_n),
    .a_cmd_en_i(a_en), .a_wr_en_i(a_wr), .a_addr_i(a_addr), .a_data_i(a_din), .a_mask_i(a_mask),
    .a_data_o(ao_d[3]), .a_valid_o(ao_v[3]),
    .b_cmd_en_i(b_en), .b_wr_en_i(b_wr), .b_addr_i(b_addr), .b_data_i(b_din), .b_mask_i(b_mask),
    .b_data_o(bo_d[3]), .b_valid_o(bo_v[3]), .collision_o(col[3]), .oob_o(oob[3]));

  // Reference model state
  logic [31:0] mdl  [NI][128];
  bit          sv   [NI][2][4];
  logic [31:0] sd   [NI][2][4];
  logic [31:0] last [NI][2];
  bit          ecol [NI], eoob [NI];
  int          cyc = 0, nassert = 0, nfail = 0;

  task automatic chk(input string tag, input int inst, input logic [31:0] obs, input logic [31:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s u%0d cyc=%0d observed=%h expected=%h", tag, inst, cyc, obs, exp);
    end
  endtask

  // Apply the commands sampled at this edge to every configuration's model
  task automatic model_edge();
    bit          en [2], wr [2], inr [2];
    logic [6:0]  ad [2];
    logic [31:0] dt [2], pre [2], post [2], resp;
    logic [3:0]  mk [2];
    int          slot;
    en = '{a_en, b_en}; wr = '{a_wr, b_wr}; ad = '{a_addr, b_addr};
    dt = '{a_din, b_din}; mk = '{a_mask, b_mask};
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        for (int p = 0; p < 2; p++) begin
          last[i][p] = '0;
          for (int s = 0; s < 4; s++) sv[i][p][s] = 1'b0;
        end
        ecol[i] = 1'b0;
        eoob[i] = 1'b0;
      end else begin
        for (int p = 0; p < 2; p++) begin
          inr[p] = int'(ad[p]) < DEP[i];
          pre[p] = inr[p] ? mdl[i][ad[p]] : 32'h0;
        end
        for (int k = 0; k < 4; k++) begin
          if (en[0] && wr[0] && inr[0] && mk[0][k])
            mdl[i][ad[0]][8*k +: 8] = dt[0][8*k +: 8];
          if (en[1] && wr[1] && inr[1] && mk[1][k] && !(en[0] && wr[0] && ad[0] == ad[1] && mk[0][k]))
            mdl[i][ad[1]][8*k +: 8] = dt[1][8*k +: 8];
        end
        for (int p = 0; p < 2; p++) post[p] = inr[p] ? mdl[i][ad[p]] : 32'h0;
        for (int p = 0; p < 2; p++) begin
          if (en[p] && (!wr[p] || MODE[i] != 0)) begin
            resp = (wr[p] && MODE[i] == 2) ? post[p] : pre[p];
            slot = (cyc + LAT[i] - 1) % 4;
            sv[i][p][slot] = 1'b1;
            sd[i][p][slot] = resp;
          end
        end
        ecol[i] = en[0] && en[1] && ad[0] == ad[1] && (wr[0] || wr[1]) && inr[0];
        eoob[i] = (en[0] && !inr[0]) || (en[1] && !inr[1]);
      end
    end
  endtask

  task automatic check_all();
    int s;
    bit ev;
    s = cyc % 4;
    for (int i = 0; i < NI; i++) begin
      for (int p = 0; p < 2; p++) begin
        ev = sv[i][p][s];
        sv[i][p][s] = 1'b0;
        if (ev) last[i][p] = sd[i][p][s];
        chk(p ? "b_valid" : "a_valid", i, p ? bo_v[i] : ao_v[i], ev);
        chk(p ? "b_data" : "a_data", i, p ? bo_d[i] : ao_d[i], last[i][p]);
      end
      chk("collision", i, col[i], ecol[i]);
      chk("oob", i, oob[i], eoob[i]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    check_all();
  endtask

  task automatic set_a(input bit en, input bit wr, input int addr, input logic [31:0] d, input logic [3:0] m);
    a_en = en; a_wr = wr; a_addr = 7'(addr); a_din = d; a_mask = m;
  endtask

  task automatic set_b(input bit en, input bit wr, input int addr, input logic [31:0] d, input logic [3:0] m);
    b_en = en; b_wr = wr; b_addr = 7'(addr); b_din = d; b_mask = m;
  endtask

  task automatic idle();
    set_a(0, 0, 0, 32'h0, 4'h0);
    set_b(0, 0, 0, 32'h0, 4'h0);
  endtask

  initial begin
    int ca, cb;
    for (int i = 0; i < NI; i++)
      for (int w = 0; w < 128; w++) mdl[i][w] = '0;
    idle();

    // Reset state
    rst_n = 1'b0;
    step(); step();
    chk("rst_a_data", 0, ao_d[0], 32'h0);
    chk("rst_b_valid", 1, bo_v[1], 32'h0);
    rst_n = 1'b1;
    step();

    // Basic write then read
    set_a(1, 1, 5, 32'hDEADBEEF, 4'hF); step();
    set_a(1, 0, 5, 32'h0, 4'h0);        step();
    chk("rd5_l1_data", 0, ao_d[0], 32'hDEADBEEF);
    chk("rd5_l1_valid", 0, ao_v[0], 32'h1);
    idle(); step();
    chk("rd5_l1_pulse", 0, ao_v[0], 32'h0);
    chk("rd5_l2_data", 1, ao_d[1], 32'hDEADBEEF);
    chk("rd5_l2_valid", 1, ao_v[1], 32'h1);

    // Byte mask merge
    set_a(1, 1, 5, 32'h11223344, 4'h5); step();
    set_a(1, 0, 5, 32'h0, 4'h0);        step();
    chk("mask_l1", 0, ao_d[0], 32'hDE22BE44);
    idle(); step();
    chk("mask_l2", 1, ao_d[1], 32'hDE22BE44);
    chk("mask_l2_valid", 1, ao_v[1], 32'h1);

    // Same-port read-during-write modes at addr 7
    set_a(1, 1, 7, 32'hAAAAAAAA, 4'hF); step();
    idle(); step();
    set_a(1, 1, 7, 32'h55555555, 4'hF); step();
    chk("nc_no_valid", 0, ao_v[0], 32'h0);
    chk("wf_valid", 2, ao_v[2], 32'h1);
    chk("wf_data", 2, ao_d[2], 32'h55555555);
    idle(); step();
    chk("rf_valid", 1, ao_v[1], 32'h1);
    chk("rf_data", 1, ao_d[1], 32'hAAAAAAAA);
    chk("nc_l2_no_valid", 3, ao_v[3], 32'h0);

    // Cross-port collisions at addr 9
    set_a(1, 1, 9, 32'h000000FF, 4'h1); set_b(1, 0, 9, 32'h0, 4'h0); step();
    chk("col_rw_flag", 0, col[0], 32'h1);
    chk("col_rw_bdata", 0, bo_d[0], 32'h0);
    chk("col_rw_bvalid", 0, bo_v[0], 32'h1);
    set_a(1, 1, 9, 32'h0000AAAA, 4'h1); set_b(1, 1, 9, 32'h0000BBBB, 4'h3); step();
    chk("col_ww_flag", 0, col[0], 32'h1);
    set_a(1, 0, 9, 32'h0, 4'h0); set_b(0, 0, 0, 32'h0, 4'h0); step();
    chk("col_ww_merge", 0, ao_d[0], 32'h0000BBAA);
    idle(); step();

    // Back-to-back reads on both ports
    ca = 0; cb = 0;
    for (int n = 0; n < 18; n++) begin
      if (n < 16) begin
        set_a(1, 0, n, 32'h0, 4'h0);
        set_b(1, 0, 15 - n, 32'h0, 4'h0);
      end else idle();
      step();
      ca += int'(ao_v[1]);
      cb += int'(bo_v[1]);
    end
    chk("b2b_a_count", 1, ca, 16);
    chk("b2b_b_count", 1, cb, 16);

    // Out-of-range access
    set_a(1, 1, 100, 32'h12345678, 4'hF); step();
    chk("oob_flag", 0, oob[0], 32'h1);
    chk("oob_pow2_none", 3, oob[3], 32'h0);
    set_a(1, 0, 100, 32'h0, 4'h0); step();
    chk("oob_rd_data", 0, ao_d[0], 32'h0);
    chk("oob_rd_valid", 0, ao_v[0], 32'h1);
    idle(); step();

    // Reset while a read is in flight
    set_a(1, 0, 5, 32'h0, 4'h0); step();
    idle();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_l2_valid", 1, ao_v[1], 32'h0);
    chk("rst_mid_l2_data", 1, ao_d[1], 32'h0);
    chk("rst_mid_l1_data", 0, ao_d[0], 32'h0);
    step();
    rst_n = 1'b1;
    step();
    set_a(1, 0, 5, 32'h0, 4'h0); step();
    chk("post_rst_rd", 0, ao_d[0], 32'hDE22BE44);
    idle(); step();
    chk("post_rst_rd_l2", 1, ao_d[1], 32'hDE22BE44);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      if (n % 200 == 199) begin
        idle();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end else begin
        set_a($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
              ($urandom_range(0, 9) == 0) ? int'($urandom_range(96, 127)) : int'($urandom_range(0, 11)),
              $urandom, 4'($urandom_range(0, 15)));
        set_b($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
              ($urandom_range(0, 9) == 0) ? int'($urandom_range(96, 127)) : int'($urandom_range(0, 11)),
              $urandom, 4'($urandom_range(0, 15)));
      end
      step();
    end
    idle(); step(); step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end
endmodule

// File: doc/bram_dual_port_pipelined.md
Name: bram_dual_port_pipelined

Overview:
True dual-port block RAM with per-byte write masks, selectable read latency and read-during-write mode, plus an output-valid pipeline and collision flagging. Successor to the single-port scratch BRAM used by the memory-controller soft-core buffers. Lets a request path and a response path (e.g. command fill and readback) share one array concurrently. Memory contents are not reset; only the output and valid pipeline are.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
BRAM_DEPTH, 128, number of words; need not be a power of two.
READ_LATENCY, 1, cycles from accepted command to data/valid; legal values 1 or 2.
RDW_MODE, "NO_CHANGE", same-port write behaviour: "NO_CHANGE", "READ_FIRST" or "WRITE_FIRST".
ADDR_WIDTH (localparam), $clog2(BRAM_DEPTH), address width.

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
rst_ni  in  1  asynchronous active-low reset.
a_cmd_en_i  in  1  port A command enable.
a_wr_en_i  in  1  port A write (1) / read (0); qualified by a_cmd_en_i.
a_addr_i  in  ADDR_WIDTH  port A word address.
a_data_i  in  DATA_WIDTH  port A write data.
a_mask_i  in  DATA_WIDTH/8  port A byte enables; bit k covers bits [8k+7:8k].
a_data_o  out  DATA_WIDTH  port A read data.
a_valid_o  out  1  port A read data valid, one-cycle pulse per returned word.
b_cmd_en_i, b_wr_en_i, b_addr_i, b_data_i, b_mask_i, b_data_o, b_valid_o  same as port A, for port B.
collision_o  out  1  one-cycle pulse: same-address access on both ports with at least one write.
oob_o  out  1  one-cycle pulse: either port addressed >= BRAM_DEPTH.

Behaviour:
- Reset (asynchronous assert, synchronous-to-clock release): a_data_o, b_data_o = 0; a_valid_o, b_valid_o, collision_o, oob_o = 0; all in-flight pipeline stages cleared. Array contents are untouched.
- Reset asserted mid-operation: any in-flight read is discarded and produces no valid pulse. A write presented on the same edge as reset assertion is not guaranteed.
- Read accepted: cmd_en=1, wr_en=0, address in range.
  - READ_LATENCY=1: word is on data_o with valid_o=1 on the next cycle.
  - READ_LATENCY=2: the array output is registered once more; data/valid appear 2 cycles after accept.
- Read throughput: one command per port per cycle at either latency, fully pipelined.
- data_o holds its last value when no valid is being produced.
- Write accepted: cmd_en=1, wr_en=1. Only bytes with mask=1 are updated; a mask of 0 is a no-op write. Output depends on RDW_MODE:
  - NO_CHANGE: no valid pulse; data_o unchanged.
  - READ_FIRST: valid pulse after READ_LATENCY carrying the pre-write word.
  - WRITE_FIRST: valid pulse after READ_LATENCY carrying the merged post-write word.
- Cross-port same-cycle, same address:
  - One port reads, the other writes: the reader returns the pre-write word, in all modes. collision_o pulses on the next cycle.
  - Both ports write: per byte, A wins where a_mask=1; B's bytes are written where a_mask=0 and b_mask=1. collision_o pulses on the next cycle.
  - Both ports read: no collision is flagged.
- collision_o and oob_o are registered with fixed latency 1, independent of READ_LATENCY.
- Out-of-range address (addr >= BRAM_DEPTH, only possible for non-power-of-two depth):
  - Writes are dropped.
  - Reads return 0 with the normal valid pulse.
  - oob_o pulses on the next cycle.
- Initial (simulation) array contents are 0.

Test Plan:
- Reset, then write A addr 5 = 0xDEADBEEF, mask 0xF; next cycle read A addr 5 (lat 1) -> one cycle after the read, a_data_o = 0xDEADBEEF, a_valid_o = 1 for exactly one cycle.
- Mask: write 0x11223344 mask 0x5 over 0xDEADBEEF at addr 5, then read -> 0xDE22BE44. Repeat with READ_LATENCY=2 -> same data, valid 2 cycles after the read is accepted.
- RDW modes at addr 7 holding 0xAAAAAAAA, write 0x55555555 mask 0xF:
  - NO_CHANGE -> no valid pulse.
  - READ_FIRST -> valid with 0xAAAAAAAA.
  - WRITE_FIRST -> valid with 0x55555555.
- Collisions at addr 9 holding 0:
  - A writes 0x000000FF mask 0x1 while B reads addr 9 -> b_data_o = 0; collision_o = 1 next cycle.
  - A writes 0x0000AAAA mask 0x1 and B writes 0x0000BBBB mask 0x3 in the same cycle -> a subsequent read of addr 9 returns 0x0000BBAA.
- Back-to-back reads on both ports of addrs 0..15, READ_LATENCY=2 -> 16 consecutive valid pulses per port, in order, with no gaps.
- BRAM_DEPTH=100: write addr 100 -> oob_o pulse, array unchanged. Separately, issue a read, assert rst_ni=0 one cycle later -> no valid pulse, outputs are 0 during reset, and the data previously written is still readable after release.
